// File: rtl/aes_tbox_lookup_if.sv
// Handshake bundle for aes_tbox_lookup.
// Input channel : in_valid/in_ready, in_bytes (8 bits per lane), in_rot (2 bits per lane),
//                 in_dec (shared encrypt/decrypt select).
// Output channel: out_valid/out_ready, out_words (32 bits per lane), out_xor (XOR of all lanes).
// master = producer of transactions / consumer of results; slave = the T-box unit.
interface aes_tbox_lookup_if #(parameter int NLANES = 4);
  logic                   in_valid;
  logic                   in_ready;
  logic [8*NLANES-1:0]    in_bytes;
  logic [2*NLANES-1:0]    in_rot;
  logic                   in_dec;
  logic                   out_valid;
  logic                   out_ready;
  logic [32*NLANES-1:0]   out_words;
  logic [31:0]            out_xor;

  modport master (
    output in_valid, in_bytes, in_rot, in_dec, out_ready,
    input  in_ready, out_valid, out_words, out_xor
  );

  modport slave (
    input  in_valid, in_bytes, in_rot, in_dec, out_ready,
    output in_ready, out_valid, out_words, out_xor
  );
endinterface

// File: rtl/aes_tbox_lookup.sv
// Multi-lane AES T-table unit. Each lane maps one byte to a 32-bit Te_r / Td_r word;
// the S-box / inverse S-box are computed arithmetically (GF(2^8) inversion + affine map).
// Two-stage valid/ready pipeline: S1 captures the request, S2 computes and holds the result.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - aes_tbox_lookup_if.slave (input request channel, output result channel)
module aes_tbox_lookup #(
  parameter int NLANES = 4
) (
  input  logic              clk,
  input  logic              reset,
  aes_tbox_lookup_if.slave  bus
);

  // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1 (0x11B).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2*a^4*...*a^128; maps 0 to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] i;
    i = gf_inv(b);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  // Undo the affine map first, then invert.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] tword(input logic [7:0] b, input logic [1:0] r, input logic dec);
    logic [7:0]  s;
    logic [31:0] w0;
    logic [31:0] w;
    s  = dec ? inv_sbox(b) : sbox(b);
    w0 = dec ? {gf_mul(8'h0e, s), gf_mul(8'h09, s), gf_mul(8'h0d, s), gf_mul(8'h0b, s)}
             : {gf_mul(8'h02, s), s, s, gf_mul(8'h03, s)};
    case (r)
      2'd0:    w = w0;
      2'd1:    w = {w0[7:0],  w0[31:8]};
      2'd2:    w = {w0[15:0], w0[31:16]};
      default: w = {w0[23:0], w0[31:24]};
    endcase
    return w;
  endfunction

  logic                  rdy_en;
  logic                  vld_p1;
  logic                  vld_p2;
  logic                  s2_load;
  logic                  accept;
  logic [8*NLANES-1:0]   bytes_p1;
  logic [2*NLANES-1:0]   rot_p1;
  logic                  dec_p1;
  logic [32*NLANES-1:0]  words_c;
  logic [31:0]           xor_c;
  logic [32*NLANES-1:0]  words_p2;
  logic [31:0]           xor_p2;

  // S2 may take new data when empty or when its result leaves this cycle.
  assign s2_load      = !vld_p2 || bus.out_ready;
  // rdy_en keeps in_ready low until the first edge after reset release.
  assign bus.in_ready = rdy_en && (!vld_p1 || s2_load);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept)       vld_p1 <= 1'b1;
      else if (s2_load) vld_p1 <= 1'b0;
      if (s2_load)      vld_p2 <= vld_p1;
    end
  end

  // ---- S1: request capture ----
  always_ff @(posedge clk) begin
    if (accept) begin
      bytes_p1 <= bus.in_bytes;
      rot_p1   <= bus.in_rot;
      dec_p1   <= bus.in_dec;
    end
  end

  // ---- S1 -> S2: per-lane T-table evaluation ----
  always_comb begin
    words_c = '0;
    xor_c   = 32'h0;
    for (int i = 0; i < NLANES; i++) begin
      words_c[32*i +: 32] = tword(bytes_p1[8*i +: 8], rot_p1[2*i +: 2], dec_p1);
      xor_c               = xor_c ^ words_c[32*i +: 32];
    end
  end

  // ---- S2: result registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_p2 <= '0;
      xor_p2   <= 32'h0;
    end else if (s2_load && vld_p1) begin
      words_p2 <= words_c;
      xor_p2   <= xor_c;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_words = words_p2;
  assign bus.out_xor   = xor_p2;

endmodule

// File: tb/tb_aes_tbox_lookup.sv
module tb_aes_tbox_lookup;
  localparam int NL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_tbox_lookup_if #(.NLANES(NL)) bus();
  aes_tbox_lookup #(.NLANES(NL)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [127:0] w;
    logic [31:0]  x;
    int           cyc;
    bit           hk;
    logic [31:0]  kw;
    bit           hx;
    logic [31:0]  kx;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   since = 0;
  bit   lat_chk = 1'b0;
  int   or_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
  bit   cur_hk = 1'b0;
  logic [31:0] cur_kw = 32'h0;
  bit   cur_hx = 1'b0;
  logic [31:0] cur_kx = 32'h0;
  bit   prev_stall = 1'b0;
  logic [127:0] prev_w;
  logic [31:0]  prev_x;
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? 8'({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from the FIPS-197 bitwise affine formula over a brute-force inverse.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      logic [7:0] c = 8'h63;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [7:0] b, input logic [1:0] r, input logic dec);
    logic [7:0]  s;
    logic [31:0] w;
    s = dec ? isb[b] : sb[b];
    w = dec ? {gm(8'h0e, s), gm(8'h09, s), gm(8'h0d, s), gm(8'h0b, s)}
            : {gm(8'h02, s), s, s, gm(8'h03, s)};
    for (int k = 0; k < int'(r); k++) w = {w[7:0], w[31:8]};
    return w;
  endfunction

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      since = 0;
      prev_stall = 1'b0;
    end else begin
      cyc++;
      since++;
      if (since >= 2)
        chk("in_ready", 128'(bus.in_ready), 128'(!(q.size() == 2 && !bus.out_ready)));
      if (prev_stall) begin
        chk("hold_valid", 128'(bus.out_valid), 128'(1));
        chk("hold_words", bus.out_words, prev_w);
        chk("hold_xor", 128'(bus.out_xor), 128'(prev_x));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 128'(1), 128'(0));
        else begin
          exp_t e;
          e = q.pop_front();
          chk("words", bus.out_words, e.w);
          chk("xor", 128'(bus.out_xor), 128'(e.x));
          if (e.hk) chk("known_lane0", 128'(bus.out_words[31:0]), 128'(e.kw));
          if (e.hx) chk("known_xor", 128'(bus.out_xor), 128'(e.kx));
          if (lat_chk) chk("latency", 128'(cyc - e.cyc), 128'(2));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_w = bus.out_words;
      prev_x = bus.out_xor;
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.x = 32'h0;
        e.w = '0;
        for (int i = 0; i < NL; i++) begin
          logic [31:0] lw;
          lw = model_word(bus.in_bytes[8*i +: 8], bus.in_rot[2*i +: 2], bus.in_dec);
          e.w[32*i +: 32] = lw;
          e.x ^= lw;
        end
        e.cyc = cyc;
        e.hk = cur_hk; e.kw = cur_kw;
        e.hx = cur_hx; e.kx = cur_kx;
        q.push_back(e);
      end
    end
  end

  // out_ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] by, input logic [7:0] rt, input logic dc,
                      input bit hk, input logic [31:0] kw, input bit hx, input logic [31:0] kx);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_bytes = by;
    bus.in_rot   = rt;
    bus.in_dec   = dc;
    cur_hk = hk; cur_kw = kw; cur_hx = hx; cur_kx = kx;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 128'(0), 128'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 128'(q.size()), 128'(0));
    #1;
  endtask

  task automatic known(input logic [7:0] b, input logic [1:0] r, input logic dc, input logic [31:0] k);
    send({24'h0, b}, {6'h0, r}, dc, 1'b1, k, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bytes = '0;
    bus.in_rot   = '0;
    bus.in_dec   = 1'b0;
    build_tables();
    #23;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_words", bus.out_words, 128'(0));
    chk("rst_out_xor", 128'(bus.out_xor), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_release", 128'(bus.in_ready), 128'(1));

    // Directed known-answer vectors
    lat_chk = 1'b1;
    known(8'h00, 2'd2, 1'b0, 32'h63a5c663);
    known(8'h00, 2'd0, 1'b0, 32'hc66363a5);
    known(8'h01, 2'd2, 1'b0, 32'h7c84f87c);
    known(8'h52, 2'd2, 1'b0, 32'h00000000);
    known(8'h00, 2'd0, 1'b1, 32'h51f4a750);
    known(8'h00, 2'd2, 1'b1, 32'ha75051f4);
    known(8'h63, 2'd0, 1'b1, 32'h00000000);
    // Four-lane column: lanes 0..3 = 00,01,52,00 with rot 0..3
    send(32'h00520100, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0, 1'b1, 32'hc66363a5, 1'b1, 32'h21f8ba1f);
    drain();

    // Full sweep, back-to-back; every lane covers every byte and rotation
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 4; r++)
        for (int b = 0; b < 256; b++) begin
          logic [31:0] by;
          logic [7:0]  rt;
          for (int l = 0; l < NL; l++) begin
            by[8*l +: 8] = 8'((b + 37*l) % 256);
            rt[2*l +: 2] = 2'((r + l) % 4);
          end
          send(by, rt, 1'(m), 1'b0, 32'h0, 1'b0, 32'h0);
        end
    drain();

    // Random backpressure on both sides
    lat_chk = 1'b0;
    or_mode = 1;
    for (int t = 0; t < 400; t++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      send($urandom, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0, 32'h0);
    end
    or_mode = 0;
    drain();

    // Reset with two transactions in flight
    or_mode = 2;
    @(posedge clk); #1;
    send(32'h11223344, 8'h1b, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    send(32'h55667788, 8'he4, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("full_out_valid", 128'(bus.out_valid), 128'(1));
    chk("full_in_ready", 128'(bus.in_ready), 128'(0));
    #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", 128'(bus.out_valid), 128'(0));
    chk("async_out_words", bus.out_words, 128'(0));
    q.delete();
    or_mode = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst2", 128'(bus.in_ready), 128'(1));
    repeat (3) begin @(posedge clk); #1; end
    lat_chk = 1'b1;
    known(8'h01, 2'd2, 1'b0, 32'h7c84f87c);
    drain();
    repeat (3) begin @(posedge clk); #1; end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
